writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 27 ++
 rtl/writeback_stage_load_extend.sv | 36 +++
 rtl/writeback_stage.sv | 98 +++++++++
 tb/tb_writeback_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage.
// Load encodings, width defaults and the MEM/WB register bundle.
package writeback_stage_pkg;

    localparam int XLEN_DEF = 64;
    localparam int MEMW_DEF = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_RSV = 3'b111;

    // ALU result is kept beside this bundle so XLEN stays a free parameter.
    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } mem_wb_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load lane select and sign/zero extension.
// Word-sized and reserved encodings return a sign-extended word.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int MEMW = MEMW_DEF
) (
    input  logic [MEMW-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    assign b = data[{off, 3'b000} +: 8];
    assign h = data[{off[1], 4'b0000} +: 16];
    assign w = data[31:0];

    always_comb begin
        ext = '0;
        unique case (funct3)
            F3_LB:  ext = {{(XLEN-8){b[7]}}, b};
            F3_LH:  ext = {{(XLEN-16){h[15]}}, h};
            F3_LW, F3_LD, F3_RSV:
                    ext = {{(XLEN-32){w[31]}}, w};
            F3_LBU: ext = {{(XLEN-8){1'b0}}, b};
            F3_LHU: ext = {{(XLEN-16){1'b0}}, h};
            F3_LWU: ext = {{(XLEN-32){1'b0}}, w};
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load data hold buffer and retire counter.
// Drives the register-file write port.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int MEMW = MEMW_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            mem_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [4:0]      rd_i,
    input  logic [2:0]      funct3_i,
    input  logic [MEMW-1:0] mem_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [31:0]     retire_cnt_o
);

    mem_wb_t         wb_q;
    logic [XLEN-1:0] alu_q;
    logic            hold_valid;
    logic [MEMW-1:0] hold_data;
    logic [31:0]     retire_cnt;
    logic [MEMW-1:0] load_data;
    logic [XLEN-1:0] load_ext;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_q  <= '0;
            alu_q <= '0;
        end else begin
            if (!stall_i) begin
                wb_q.valid      <= mem_valid_i;
                wb_q.mem_to_reg <= mem_to_reg_i;
                wb_q.reg_write  <= reg_write_i;
                wb_q.rd         <= rd_i;
                wb_q.funct3     <= funct3_i;
                wb_q.off        <= alu_result_i[1:0];
                alu_q           <= alu_result_i;
            end
            if (flush_i) begin
                wb_q.valid <= 1'b0;
            end
        end
    end

    // Memory output moves on during a stall, so the load word is latched once.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (stall_i && !flush_i) begin
            if (!hold_valid && wb_q.valid && wb_q.mem_to_reg) begin
                hold_valid <= 1'b1;
                hold_data  <= mem_data_i;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            retire_cnt <= '0;
        end else if (wb_q.valid && !stall_i) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign load_data = hold_valid ? hold_data : mem_data_i;

    load_extend #(
        .XLEN (XLEN),
        .MEMW (MEMW)
    ) u_load_extend (
        .data   (load_data),
        .funct3 (wb_q.funct3),
        .off    (wb_q.off),
        .ext    (load_ext)
    );

    assign wb_valid_o   = wb_q.valid;
    assign wb_rd_o      = wb_q.rd;
    assign wb_data_o    = wb_q.mem_to_reg ? load_ext : alu_q;
    assign retire_cnt_o = retire_cnt;
    assign wb_we_o      = wb_q.valid & wb_q.reg_write
                        & (wb_q.rd != 5'd0)
                        & ~stall_i & ~reset_i;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage.
// Stimulus queues expected outputs; the monitor compares at negedge.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mv;
    logic [63:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] mdata;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [31:0] cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        bit          is_hold;
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    writeback_stage dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .mem_valid_i  (mv),
        .alu_result_i (alu),
        .mem_to_reg_i (m2r),
        .reg_write_i  (rw),
        .rd_i         (rd),
        .funct3_i     (f3),
        .mem_data_i   (mdata),
        .stall_i      (stall),
        .flush_i      (flush),
        .wb_valid_o   (wb_valid),
        .wb_we_o      (wb_we),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .retire_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string fld,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%h want=%h", name, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_hold) begin
                cmp(e.name, "hold_valid", 64'(dut.hold_valid), 64'(e.v));
            end else begin
                cmp(e.name, "valid", 64'(wb_valid), 64'(e.v));
                cmp(e.name, "we", 64'(wb_we), 64'(e.we));
                cmp(e.name, "rd", 64'(wb_rd), 64'(e.rd));
                cmp(e.name, "data", wb_data, e.data);
                cmp(e.name, "cnt", 64'(cnt), 64'(e.cnt));
            end
        end
    end

    task automatic step(
        input string name,
        input logic i_v, input logic [63:0] i_alu, input logic i_m2r,
        input logic i_rw, input logic [4:0] i_rd, input logic [2:0] i_f3,
        input logic [31:0] i_md, input logic i_st, input logic i_fl,
        input logic i_rst,
        input logic x_v, input logic x_we, input logic [4:0] x_rd,
        input logic [63:0] x_data, input logic [31:0] x_cnt);
        exp_t x;
        @(posedge clk);
        #1;
        mv = i_v; alu = i_alu; m2r = i_m2r; rw = i_rw;
        rd = i_rd; f3 = i_f3; mdata = i_md;
        stall = i_st; flush = i_fl; rst = i_rst;
        x.name = name; x.is_hold = 1'b0;
        x.v = x_v; x.we = x_we; x.rd = x_rd;
        x.data = x_data; x.cnt = x_cnt;
        sb.push_back(x);
    endtask

    task automatic expect_hold(input string name, input logic hv);
        exp_t x;
        x.name = name; x.is_hold = 1'b1; x.v = hv;
        x.we = 1'b0; x.rd = '0; x.data = '0; x.cnt = '0;
        sb.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mv = 1'b0; alu = '0; m2r = 1'b0; rw = 1'b0;
        rd = '0; f3 = '0; mdata = '0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        //    name     v  alu         m2r rw rd  f3    mdata          st fl rs  ev ewe erd edata                   ecnt
        step("reset", 1, 64'h1003,    1, 1, 5,  3'b000, 32'h0,        0, 0, 0, 0, 0, 0,  64'h0,                  32'd0);
        step("lb",    1, 64'h2002,    1, 1, 6,  3'b101, 32'h80FF_FF7F, 0, 0, 0, 1, 1, 5,  64'hFFFF_FFFF_FFFF_FF80, 32'd0);
        step("lhu",   1, 64'h1234,    0, 1, 0,  3'b000, 32'hBEEF_1234, 0, 0, 0, 1, 1, 6,  64'h0000_0000_0000_BEEF, 32'd1);
        step("x0",    1, 64'h3000,    1, 1, 7,  3'b010, 32'h0,        0, 0, 0, 1, 0, 0,  64'h1234,               32'd2);
        step("st1",   1, 64'hAAAA,    0, 1, 8,  3'b000, 32'h8000_0001, 1, 0, 0, 1, 0, 7,  64'hFFFF_FFFF_8000_0001, 32'd3);
        step("st2",   1, 64'hAAAA,    0, 1, 8,  3'b000, 32'h1111_1111, 1, 0, 0, 1, 0, 7,  64'hFFFF_FFFF_8000_0001, 32'd3);
        step("st3",   1, 64'hAAAA,    0, 1, 8,  3'b000, 32'h2222_2222, 1, 0, 0, 1, 0, 7,  64'hFFFF_FFFF_8000_0001, 32'd3);
        step("unst",  1, 64'h4001,    1, 1, 9,  3'b100, 32'h3333_3333, 0, 0, 0, 1, 1, 7,  64'hFFFF_FFFF_8000_0001, 32'd3);
        step("lbu",   1, 64'h55,      0, 1, 10, 3'b000, 32'h0000_C300, 1, 0, 0, 1, 0, 9,  64'hC3,                 32'd4);
        step("fl_st", 1, 64'h55,      0, 1, 10, 3'b000, 32'hFFFF_FFFF, 1, 1, 0, 1, 0, 9,  64'hC3,                 32'd4);
        expect_hold("hold_set", 1'b1);
        step("killed", 1, 64'hFFFF_0000_0000_0001, 0, 1, 11, 3'b000, 32'h0, 0, 0, 0, 0, 0, 9, 64'h0,          32'd4);
        expect_hold("hold_clr", 1'b0);
        step("alu",   1, 64'h77,      0, 0, 12, 3'b000, 32'h0,        0, 0, 0, 1, 1, 11, 64'hFFFF_0000_0000_0001, 32'd4);
        step("norw",  1, 64'h99,      0, 1, 13, 3'b000, 32'h0,        0, 0, 0, 1, 0, 12, 64'h77,                 32'd5);
        step("in_rst", 1, 64'h0,      0, 0, 0,  3'b000, 32'h0,        0, 0, 1, 1, 0, 13, 64'h99,                 32'd6);
        step("post_rst", 0, 64'h0,    0, 0, 0,  3'b000, 32'h0,        0, 0, 0, 0, 0, 0,  64'h0,                  32'd0);
        step("preload", 1, 64'h1,     0, 1, 1,  3'b000, 32'h0,        0, 0, 0, 0, 0, 0,  64'h0,                  32'hFFFF_FFFE);
        force dut.retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt;
        step("wrap1", 1, 64'h2,       0, 1, 2,  3'b000, 32'h0,        0, 0, 0, 1, 1, 1,  64'h1,                  32'hFFFF_FFFE);
        step("wrap2", 0, 64'h0,       0, 0, 0,  3'b000, 32'h0,        0, 0, 0, 1, 1, 2,  64'h2,                  32'hFFFF_FFFF);
        step("wrap3", 0, 64'h0,       0, 0, 0,  3'b000, 32'h0,        0, 0, 0, 0, 0, 0,  64'h0,                  32'd0);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
